pipe_adder: RTL and testbench
=============================

# pipe_adder

Parametrised, pipelined ripple-chunk adder. The next generation of the team's 16-bit four-chunk adder. Operands are split into CHUNK-bit slices and each slice is added in its own pipeline stage, with the carry registered between stages, so clock frequency is set by one chunk rather than the full width. A valid/ready handshake on both sides lets the block sit directly in streaming datapaths and accept one operation per cycle.

## Interface
- WIDTH, 16: operand and sum width. Must be a multiple of CHUNK.
- CHUNK, 4: bits added per pipeline stage. NSTG = WIDTH/CHUNK.
- clk  in  1: clock. All logic is on the rising edge.
- rst  in  1: synchronous, active-high reset.
- in_valid  in  1: the input operation is valid.
- in_ready  out  1: the block accepts the input this cycle.
- in_a  in  WIDTH: operand A.
- in_b  in  WIDTH: operand B.
- in_cin  in  1: carry-in to bit 0.
- in_sub  in  1: subtract select. Present only with PIPE_ADDER_SUB_EN.
- out_valid  out  1: a result is presented.
- out_ready  in  1: the consumer accepts the result.
- out_sum  out  WIDTH: sum.
- out_cout  out  1: carry-out of the MSB.
- out_ovf  out  1: two's-complement signed overflow.

## Operation
- Stage k (0..NSTG-1) adds slice k of A and B plus the carry registered by stage k-1. Stage 0 uses in_cin.
- Slices above k travel unmodified through skew registers. Completed lower sum slices are carried forward alongside them.
- Each stage holds a valid bit. The result leaves stage NSTG-1.
- out_sum = (A + B + cin) mod 2^WIDTH.
- out_cout is the carry out of bit WIDTH-1.
- out_ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), where B' is the effective B operand.
- Stall: the pipeline advances when adv = !out_valid || out_ready.
  - in_ready = adv.
  - A transfer occurs when in_valid && in_ready.
  - When adv=0, every stage (data and valid) holds.
- Bubbles: if adv=1 and no transfer occurs, a 0 valid bit enters stage 0. Bubbles are not compressed; the pipeline is fixed-latency.
- out_sum, out_cout and out_ovf are stable while out_valid && !out_ready.
- Reset:
  - All stage valid bits are cleared, so out_valid=0.
  - out_sum, out_cout and out_ovf are 0.
  - in_ready=1 in the first cycle after reset.
  - Reset asserted mid-operation discards all in-flight results. None are emitted.
- Simultaneous input accept and output drain with a full pipeline is legal and sustains throughput of 1 per cycle.

## Timing
- Latency: an input accepted at edge t gives out_valid=1 after edge t+NSTG, counting only non-stalled cycles.
- Throughput: 1 operation per cycle while out_ready=1.
- in_ready is combinational from out_ready and the last-stage valid bit. There is no combinational path from in_valid to in_ready.
- The critical path is one CHUNK-bit add plus carry-in.

## Configuration
- PIPE_ADDER_SUB_EN defined:
  - The in_sub port exists and is captured with the operands.
  - When in_sub=1, the effective B is ~in_b and the effective carry-in is 1, so the result is A−B. in_cin is ignored.
  - out_cout=1 means no borrow.
  - out_ovf uses the effective B.
- PIPE_ADDER_SUB_EN undefined:
  - There is no in_sub port.
  - The block is add-only, B is used directly, and in_cin is honoured.

## Structure
- Package pipe_adder_pkg holds:
  - the NSTG derivation function;
  - a stage-record typedef {valid, a_hi, b_hi, sum_lo, carry, sub};
  - the elaboration check WIDTH % CHUNK == 0.
- Sub-module pipe_adder_stage: one CHUNK-bit add plus the stage register with hold-on-stall. It is instantiated NSTG times by a generate loop.
- The top level handles skew routing, the handshake and overflow.

## Test plan
All scenarios use WIDTH=16, CHUNK=4, NSTG=4.
- Reset, then idle → out_valid=0, out_sum=0 and in_ready=1 in every cycle. Assert rst mid-stream → no stale outputs appear afterwards.
- Single op A=0x0FFF, B=0x0001, cin=0 → exactly 4 cycles later: out_sum=0x1000, out_cout=0, out_ovf=0. Exercises the carry ripple across three stages.
- Overflow and carry:
  - A=0x7FFF, B=0x0001 → sum=0x8000, ovf=1, cout=0.
  - A=0xFFFF, B=0x0001, cin=1 → sum=0x0001, cout=1, ovf=0.
- Back-to-back stream of 64 random operations with out_ready=1 → one result per cycle, matching the reference model in order.
- Backpressure: hold out_ready=0 for 5 cycles with a full pipeline → in_ready=0 and out_sum stable. On release, all results are delivered in order with none lost or duplicated.
- With PIPE_ADDER_SUB_EN: A=0x0005, B=0x0007, in_sub=1 → sum=0xFFFE, cout=0. A=0x8000, B=0x0001, in_sub=1 → sum=0x7FFF, ovf=1.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - shared types and elaboration helpers for the chunked pipelined adder
package pipe_adder_pkg;

  // Record fields are sized for the widest supported operand; MAXW must exceed WIDTH so the
  // sign-extension of A and effective B survives to the last stage for overflow detection.
  localparam int MAXW = 64;

  typedef struct packed {
    logic            valid;
    logic [MAXW-1:0] a_hi;
    logic [MAXW-1:0] b_hi;
    logic [MAXW-1:0] sum_lo;
    logic            carry;
    logic            sub;
  } stage_t;

  function automatic int nstg(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic bit width_ok(input int width, input int chunk);
    return (chunk > 0) && ((width % chunk) == 0) && (width < MAXW);
  endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// rtl/pipe_adder_stage.sv - one CHUNK-bit add slice with its hold-on-stall stage register
module pipe_adder_stage
  import pipe_adder_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   adv,
  input  stage_t d,
  output stage_t q
);

  logic [CHUNK:0] add;
  stage_t         nxt;
  logic           unused_sum;

  // Operands shift down one slice per stage; finished sum slices enter from the top so the
  // last stage holds the full sum in the upper WIDTH bits of sum_lo.
  always_comb begin
    add        = {1'b0, d.a_hi[CHUNK-1:0]} + {1'b0, d.b_hi[CHUNK-1:0]} + {{CHUNK{1'b0}}, d.carry};
    nxt        = d;
    nxt.a_hi   = d.a_hi >> CHUNK;
    nxt.b_hi   = d.b_hi >> CHUNK;
    nxt.sum_lo = {add[CHUNK-1:0], d.sum_lo[MAXW-1:CHUNK]};
    nxt.carry  = add[CHUNK];
  end

  assign unused_sum = ^d.sum_lo[CHUNK-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (adv) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined chunked adder with valid/ready on both sides
// Optional subtract mode: define PIPE_ADDER_SUB_EN to add the in_sub port.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NSTG = nstg(WIDTH, CHUNK);

  if (!width_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a multiple of CHUNK and below MAXW");
  end

  logic             adv;
  logic             xfer;
  logic             sub_sel;
  logic [WIDTH-1:0] b_eff;
  stage_t           entry;
  stage_t           stq [NSTG];
  stage_t           last;
  logic             unused_top;

`ifdef PIPE_ADDER_SUB_EN
  assign sub_sel = in_sub;
`else
  assign sub_sel = 1'b0;
`endif

  assign last     = stq[NSTG-1];
  assign adv      = !last.valid || out_ready;
  assign in_ready = adv;
  assign xfer     = in_valid && adv;
  assign b_eff    = sub_sel ? ~in_b : in_b;

  // Non-transfer cycles inject an all-zero bubble so idle outputs read as zero.
  always_comb begin
    entry = '0;
    if (xfer) begin
      entry.valid = 1'b1;
      entry.a_hi  = {{(MAXW-WIDTH){in_a[WIDTH-1]}}, in_a};
      entry.b_hi  = {{(MAXW-WIDTH){b_eff[WIDTH-1]}}, b_eff};
      entry.carry = sub_sel | in_cin;
      entry.sub   = sub_sel;
    end
  end

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    stage_t d;
    if (k == 0) begin : g_first
      assign d = entry;
    end else begin : g_next
      assign d = stq[k-1];
    end
    pipe_adder_stage #(.CHUNK(CHUNK)) u_stage (
      .clk (clk),
      .rst (rst),
      .adv (adv),
      .d   (d),
      .q   (stq[k])
    );
  end

  // After NSTG shifts, bit 0 of a_hi/b_hi is the sign-extension of A and effective B.
  assign out_valid = last.valid;
  assign out_sum   = last.sum_lo[MAXW-1 -: WIDTH];
  assign out_cout  = last.carry;
  assign out_ovf   = (last.a_hi[0] == last.b_hi[0]) && (out_sum[WIDTH-1] != last.a_hi[0]);

  assign unused_top = ^{last.a_hi[MAXW-1:1], last.b_hi[MAXW-1:1],
                        last.sum_lo[MAXW-WIDTH-1:0], last.sub};

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - scoreboard bench for pipe_adder (WIDTH=16, CHUNK=4)
module tb_pipe_adder;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_cin;
`ifdef PIPE_ADDER_SUB_EN
  logic        in_sub;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  int   checks   = 0;
  int   failures = 0;
  int   pops     = 0;
  int   cyc      = 0;
  exp_t sb[$];

  pipe_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef PIPE_ADDER_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on the effective operands.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    exp_t        e;
    logic [15:0] beff;
    int          c;
    int          full;
    int          ss;
    beff   = sub ? ~b : b;
    c      = sub ? 1 : int'(cin);
    full   = int'(a) + int'(beff) + c;
    ss     = int'($signed(a)) + int'($signed(beff)) + c;
    e.sum  = full[15:0];
    e.cout = (full >= 65536);
    e.ovf  = (ss > 32767) || (ss < -32768);
    return e;
  endfunction

  // Monitor: compare the head of the scoreboard whenever a result is presented.
  initial forever begin
    @(negedge clk);
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", {31'b0, out_valid}, 32'h0);
      end else begin
        check("result", {15'b0, out_ovf, out_cout, out_sum},
              {15'b0, sb[0].ovf, sb[0].cout, sb[0].sum});
        if (out_ready) begin
          void'(sb.pop_front());
          pops++;
        end
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic sub, input exp_t e);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
`ifdef PIPE_ADDER_SUB_EN
    in_sub   = sub;
`else
    if (sub) $display("note: subtract request ignored in add-only build");
`endif
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", {31'b0, in_ready}, 32'h1);
    else sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic rand_op();
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    a   = 16'($urandom);
    b   = 16'($urandom);
    cin = 1'($urandom);
`ifdef PIPE_ADDER_SUB_EN
    sub = 1'($urandom);
`else
    sub = 1'b0;
`endif
    send(a, b, cin, sub, model(a, b, cin, sub));
  endtask

  task automatic drain(input string name);
    repeat (10) @(posedge clk);
    #1;
    check(name, sb.size(), 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : main
    int dc;
    int n;
    int p0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
`ifdef PIPE_ADDER_SUB_EN
    in_sub    = 1'b0;
`endif
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("idle_out_valid", {31'b0, out_valid}, 32'h0);
      check("idle_out_sum", {16'b0, out_sum}, 32'h0);
      check("idle_in_ready", {31'b0, in_ready}, 32'h1);
    end
    @(posedge clk);
    #1;

    // Carry ripple across three stages plus exact latency
    dc = cyc;
    send(16'h0FFF, 16'h0001, 1'b0, 1'b0, '{16'h1000, 1'b0, 1'b0});
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("latency", cyc - dc, 32'd4);
    @(posedge clk);
    #1;

    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1});
    send(16'hFFFF, 16'h0001, 1'b1, 1'b0, '{16'h0001, 1'b1, 1'b0});
`ifdef PIPE_ADDER_SUB_EN
    send(16'h0005, 16'h0007, 1'b0, 1'b1, '{16'hFFFE, 1'b0, 1'b0});
    send(16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1});
`endif
    drain("drain_directed");

    // Back-to-back stream: one result per cycle
    p0 = pops;
    for (int i = 0; i < 64; i++) rand_op();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("stream_count_m1", pops - p0, 32'd63);
    @(negedge clk);
    #1;
    check("stream_count", pops - p0, 32'd64);
    drain("drain_stream");

    // Backpressure with a full pipeline
    p0 = pops;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) rand_op();
    fork
      rand_op();
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("stall_in_ready", {31'b0, in_ready}, 32'h0);
          check("stall_out_valid", {31'b0, out_valid}, 32'h1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");
    check("backpressure_count", pops - p0, 32'd5);

    // Random consumer readiness
    fork
      for (int i = 0; i < 40; i++) rand_op();
      begin
        repeat (100) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom);
        end
      end
    join
    out_ready = 1'b1;
    drain("drain_random_ready");

    // Reset mid-stream discards in-flight results
    for (int i = 0; i < 3; i++) rand_op();
    out_ready = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1 sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_reset_out_valid", {31'b0, out_valid}, 32'h0);
      check("post_reset_out_sum", {16'b0, out_sum}, 32'h0);
    end
    @(posedge clk);
    #1;
    p0 = pops;
    rand_op();
    drain("drain_after_reset");
    check("after_reset_count", pops - p0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
